// File: rtl/mic1_io_uart.sv
// rtl/mic1_io_uart.sv - mic1 memory-mapped UART: TX FIFO + 8N1 serialiser, RX deserialiser, status register.
// Define MIC1_IO_LOOPBACK_EN to feed the RX synchroniser from ser_tx instead of ser_rx.
module mic1_io_uart #(
  parameter logic [31:0] IO_ADDR      = 32'hFFFFFFFD,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFFFFFC,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_hit,
  input  logic        ser_rx,
  output logic        ser_tx
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic data_sel, status_sel, rd_data, rd_status, wr_data;
  assign data_sel   = (io_addr == IO_ADDR);
  assign status_sel = (io_addr == STATUS_ADDR);
  assign io_hit     = data_sel | status_sel;
  assign rd_data    = io_read & data_sel;
  assign rd_status  = io_read & status_sel;
  assign wr_data    = io_write & data_sel;

  // TX FIFO
  logic [7:0]    tx_mem_q [TX_DEPTH];
  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW:0]   tx_count_q, tx_count_d;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_count_q == (PW+1)'(TX_DEPTH));
  assign tx_empty = (tx_count_q == '0);
  // A pop on the same edge frees a slot, so a push to a full FIFO is still taken.
  assign tx_push  = wr_data & (~tx_full | tx_pop);

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + PW'(tx_push);
    tx_rd_ptr_d = tx_rd_ptr_q + PW'(tx_pop);
    tx_count_d  = tx_count_q + (PW+1)'(tx_push) - (PW+1)'(tx_pop);
  end

  // TX serialiser
  state_t        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          ser_tx_q, ser_tx_d, tx_tick;

  assign tx_tick = (tx_cnt_q == BIT_END);
  assign ser_tx  = ser_tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    ser_tx_d   = ser_tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = ST_START;
          tx_shift_d = tx_mem_q[tx_rd_ptr_q];
          ser_tx_d   = 1'b0;
        end
      end
      ST_START: if (tx_tick) begin
        tx_state_d = ST_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        ser_tx_d   = tx_shift_q[0];
      end
      ST_DATA: if (tx_tick) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = ST_STOP;
          ser_tx_d   = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          ser_tx_d   = tx_shift_q[1];
        end
      end
      default: if (tx_tick) begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = ST_START;
          tx_shift_d = tx_mem_q[tx_rd_ptr_q];
          ser_tx_d   = 1'b0;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
    endcase
  end

  // RX deserialiser
  logic rx_in;
`ifdef MIC1_IO_LOOPBACK_EN
  assign rx_in = ser_tx_q;
  logic unused_ser_rx;
  assign unused_ser_rx = ser_rx;
`else
  assign rx_in = ser_rx;
`endif

  logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
  state_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_deliver, rx_ferr_set, rx_tick, rx_half;

  assign rx_tick = (rx_cnt_q == BIT_END);
  assign rx_half = (rx_cnt_q == HALF_END);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_deliver  = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) rx_state_d = ST_START;
      end
      ST_START: if (rx_half) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
      end
      default: if (rx_tick) begin
        rx_state_d  = ST_IDLE;
        rx_deliver  = rx_sync2_q;
        rx_ferr_set = ~rx_sync2_q;
      end
    endcase
  end

  // Register file and read path
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;
  logic [31:0] io_rdata_q, io_rdata_d;

  assign io_rdata = io_rdata_q;

  always_comb begin
    io_rdata_d   = io_rdata_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = frame_err_q;
    if (rd_data) begin
      io_rdata_d = rx_valid_q ? {24'h0, rx_byte_q} : 32'h0;
      rx_valid_d = 1'b0;
    end else if (rd_status) begin
      io_rdata_d   = {28'h0, frame_err_q, rx_overrun_q, tx_full, rx_valid_q};
      rx_overrun_d = 1'b0;
      frame_err_d  = 1'b0;
    end
    // A read on the delivery edge returns the old byte and frees the slot for the new one.
    if (rx_deliver) begin
      if (!rx_valid_q || rd_data) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
    if (rx_ferr_set) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= io_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_count_q   <= '0;
      tx_state_q   <= ST_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      ser_tx_q     <= 1'b1;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      io_rdata_q   <= '0;
    end else begin
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_count_q   <= tx_count_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      ser_tx_q     <= ser_tx_d;
      rx_sync1_q   <= rx_in;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_sync2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      io_rdata_q   <= io_rdata_d;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^io_wdata[31:8];

endmodule

// File: tb/tb_mic1_io_uart.sv
// tb/tb_mic1_io_uart.sv - scoreboard bench for mic1_io_uart with a transaction-level UART model.
module tb_mic1_io_uart;
  localparam int CPB = 16;
  localparam logic [31:0] IO_A = 32'hFFFFFFFD;
  localparam logic [31:0] ST_A = 32'hFFFFFFFC;

  logic clk, resetn, io_read, io_write, io_hit, ser_rx, ser_tx;
  logic [31:0] io_addr, io_wdata, io_rdata;

  mic1_io_uart #(.IO_ADDR(IO_A), .STATUS_ADDR(ST_A), .CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .io_read(io_read), .io_write(io_write),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_hit(io_hit),
    .ser_rx(ser_rx), .ser_tx(ser_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct { logic [7:0] b; bit contig; } tx_exp_t;
  tx_exp_t     tx_q[$];
  logic [31:0] rd_q[$];

  // Reference model state: the receive register, sticky flags and TX fullness
  bit         m_valid, m_ovr, m_ferr, m_tx_full;
  logic [7:0] m_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d, input bit accepted, input bit contig);
    io_write = 1'b1;
    io_addr  = a;
    io_wdata = $urandom();
    io_wdata[7:0] = d;
    if (accepted) tx_q.push_back('{b: d, contig: contig});
    @(negedge clk);
    io_write = 1'b0;
    io_addr  = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    if (a == IO_A) begin
      rd_q.push_back(m_valid ? {24'h0, m_byte} : 32'h0);
      m_valid = 1'b0;
    end else begin
      rd_q.push_back({28'h0, m_ferr, m_ovr, m_tx_full, m_valid});
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    io_read = 1'b1;
    io_addr = a;
    @(negedge clk);
    io_read = 1'b0;
    io_addr = 32'h0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = bits[i];
      idle(CPB);
    end
    ser_rx = 1'b1;
    idle(4);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_valid = 1'b1;
      m_byte  = b;
    end
  endtask

  // Read monitor: data appears the cycle after a hitting read
  initial begin
    forever begin
      @(posedge clk);
      if (resetn && io_read && io_hit) begin
        @(negedge clk);
        if (rd_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got %h expected no read", io_rdata);
        end else begin
          check("io_rdata", io_rdata, rd_q.pop_front());
        end
      end
    end
  end

  // TX monitor: every clock of a frame must carry the expected bit level
  initial begin
    int gap;
    bit ok, unexp;
    tx_exp_t e;
    logic [9:0] exp_bits;
    logic [7:0] act;
    gap = 1000;
    forever begin
      @(negedge clk);
      if (!resetn) gap = 1000;
      else if (ser_tx === 1'b0) begin
        unexp = (tx_q.size() == 0);
        e = '{b: 8'h00, contig: 1'b0};
        if (!unexp) e = tx_q.pop_front();
        exp_bits = {1'b1, e.b, 1'b0};
        ok = 1'b1;
        act = 8'h00;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k != 0) @(negedge clk);
          if (ser_tx !== exp_bits[k / CPB]) ok = 1'b0;
          if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) act[k / CPB - 1] = ser_tx;
        end
        n_checks++;
        if (!unexp && ok && (!e.contig || gap == 0)) n_pass++;
        else $display("FAIL tx_frame: got %h timing_ok=%0d gap=%0d, expected %h contig=%0d queued=%0d",
                      act, ok, gap, e.b, e.contig, !unexp);
        gap = 0;
      end else gap++;
    end
  end

  initial begin
    int op, n;
    resetn = 1'b0; io_read = 1'b0; io_write = 1'b0;
    io_addr = 32'h0; io_wdata = 32'h0; ser_rx = 1'b1;
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_tx_full = 0; m_byte = 8'h00;
    idle(2);
    check("reset_ser_tx", ser_tx, 1'b1);
    check("reset_io_rdata", io_rdata, 32'h0);
    resetn = 1'b1;
    idle(1);

    io_addr = IO_A; #1 check("hit_io", io_hit, 1'b1);
    io_addr = ST_A; #1 check("hit_status", io_hit, 1'b1);
    io_addr = 32'hFFFFFFFE; #1 check("hit_none", io_hit, 1'b0);
    io_addr = 32'h0;
    @(negedge clk);
    bus_read(ST_A);

    bus_write(IO_A, 8'h41, 1, 0);
    idle(10 * CPB + 20);

    for (int v = 8'h31; v <= 8'h35; v++) bus_write(IO_A, 8'(v), 1, v != 8'h31);
    m_tx_full = 1'b1;
    bus_read(ST_A);
    bus_write(IO_A, 8'h36, 0, 0);
    idle(5 * 10 * CPB + 20);
    m_tx_full = 1'b0;
    bus_write(ST_A, 8'h77, 0, 0);
    idle(20);
    bus_read(ST_A);

    send_rx(8'h5A, 1);
    bus_read(IO_A);
    bus_read(IO_A);
    bus_read(ST_A);

    send_rx(8'h33, 1);
    send_rx(8'h34, 1);
    bus_read(IO_A);
    bus_read(ST_A);
    send_rx(8'h35, 0);
    bus_read(ST_A);
    bus_read(IO_A);

    ser_rx = 1'b0;
    idle(3);
    ser_rx = 1'b1;
    idle(40);
    bus_read(ST_A);

    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) bus_write(IO_A, 8'($urandom()), 1, j != 0);
          idle((n + 1) * 10 * CPB + 20);
        end
        1: send_rx(8'($urandom()), $urandom_range(0, 4) != 0);
        2: bus_read(IO_A);
        default: bus_read(ST_A);
      endcase
    end

    for (int t = 0; t < 2000 && (tx_q.size() != 0 || rd_q.size() != 0); t++) @(negedge clk);
    if (tx_q.size() != 0 || rd_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d tx and %0d reads pending expected 0", tx_q.size(), rd_q.size());
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
